// File: rtl/pakin_checker.sv
// ============================================================================
// pakin_checker : four-phase receive sink that range/redundancy/sequence
//                 checks packets and exposes counters on a debug display.
// Rev 1.0
// ============================================================================
`default_nettype none

module pakin_checker #(
    parameter int PSZ      = 14,
    parameter int ASZ      = 6,
    parameter int DSZ      = 4,
    parameter int RSZ      = 4,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 14
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    input  logic [PSZ-1:0] rcv0_data,
    output logic           rcv0_ack,
    input  logic [7:0]     dbg_case,
    input  logic           dbg_doit,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);

    logic           ready_q, ready_d;
    logic           sync1_q, sync1_d;
    logic           req_s_q, req_s_d;
    logic [1:0]     state_q, state_d;
    logic [PSZ-1:0] pkt_q, pkt_d;
    logic           ack_q, ack_d;
    logic           seeded_q, seeded_d;
    logic           rng_seen_q, rng_seen_d;
    logic           red_seen_q, red_seen_d;
    logic           seq_seen_q, seq_seen_d;
    logic [ASZ-1:0] last_addr_q, last_addr_d;
    logic [DSZ-1:0] last_data_q, last_data_d;
    logic [7:0]     pkt_cnt_q, pkt_cnt_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           doit_q, doit_d;
    logic [7:0]     snap_q, snap_d;

    logic [ASZ-1:0] w_addr;
    logic [DSZ-1:0] w_data;
    logic [RSZ-1:0] w_redun;
    logic [DSZ-1:0] w_next_data;
    logic           w_rng_err, w_red_err, w_seq_err;
    logic [7:0]     w_addr8, w_data8;
    logic           unused_case_bits;

    assign unused_case_bits = ^dbg_case[7:2];

    // Display values are zero-extended or truncated to one byte.
    if (ASZ >= 8) begin : g_addr_trunc
        assign w_addr8 = last_addr_q[7:0];
    end else begin : g_addr_pad
        assign w_addr8 = {{(8-ASZ){1'b0}}, last_addr_q};
    end

    if (DSZ >= 8) begin : g_data_trunc
        assign w_data8 = last_data_q[7:0];
    end else begin : g_data_pad
        assign w_data8 = {{(8-DSZ){1'b0}}, last_data_q};
    end

    always_comb begin
        w_addr      = pkt_q[PSZ-1 -: ASZ];
        w_data      = pkt_q[RSZ +: DSZ];
        w_redun     = pkt_q[RSZ-1:0];
        w_next_data = last_data_q + DSZ'(1);
        w_rng_err   = (w_addr < MIN_A) || (w_addr > MAX_A);
        w_red_err   = w_redun != (w_addr[RSZ-1:0] ^ w_data[RSZ-1:0]);
        w_seq_err   = seeded_q && (w_data != w_next_data);

        ready_d     = 1'b1;
        sync1_d     = rcv0_req;
        req_s_d     = sync1_q;
        state_d     = state_q;
        pkt_d       = pkt_q;
        ack_d       = ack_q;
        seeded_d    = seeded_q;
        rng_seen_d  = rng_seen_q;
        red_seen_d  = red_seen_q;
        seq_seen_d  = seq_seen_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        doit_d      = dbg_doit;
        snap_d      = snap_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s_q) begin
                    pkt_d   = rcv0_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ack_d       = 1'b1;
                seeded_d    = 1'b1;
                rng_seen_d  = rng_seen_q | w_rng_err;
                red_seen_d  = red_seen_q | w_red_err;
                seq_seen_d  = seq_seen_q | w_seq_err;
                last_addr_d = w_addr;
                last_data_d = w_data;
                pkt_cnt_d   = pkt_cnt_q + 8'd1;
                if ((w_rng_err || w_red_err || w_seq_err) && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Reads the registered counters, so a coincident CHECK shows old values.
        if (dbg_doit && !doit_q) begin
            case (dbg_case[1:0])
                2'd0:    snap_d = pkt_cnt_q;
                2'd1:    snap_d = err_cnt_q;
                2'd2:    snap_d = w_addr8;
                default: snap_d = w_data8;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            sync1_q     <= 1'b0;
            req_s_q     <= 1'b0;
            state_q     <= ST_IDLE;
            pkt_q       <= '0;
            ack_q       <= 1'b0;
            seeded_q    <= 1'b0;
            rng_seen_q  <= 1'b0;
            red_seen_q  <= 1'b0;
            seq_seen_q  <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            doit_q      <= 1'b0;
            snap_q      <= '0;
        end else begin
            ready_q     <= ready_d;
            sync1_q     <= sync1_d;
            req_s_q     <= req_s_d;
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            ack_q       <= ack_d;
            seeded_q    <= seeded_d;
            rng_seen_q  <= rng_seen_d;
            red_seen_q  <= red_seen_d;
            seq_seen_q  <= seq_seen_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            doit_q      <= doit_d;
            snap_q      <= snap_d;
        end
    end

    assign ready     = ready_q;
    assign rcv0_ack  = ack_q;
    assign dbg_leds  = {seq_seen_q, red_seen_q, rng_seen_q, seeded_q};
    assign dbg_disp0 = snap_q[7:4];
    assign dbg_disp1 = snap_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_pakin_checker.sv
// ============================================================================
// tb_pakin_checker : randomized/directed bench for pakin_checker against a
//                    packet-level reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pakin_checker;

    localparam int ASZ = 6;
    localparam int DSZ = 4;
    localparam int RSZ = 4;
    localparam int PSZ = 14;

    logic           i_clk = 1'b0;
    logic           reset = 1'b0;
    logic           ready;
    logic           rcv0_req = 1'b0;
    logic [PSZ-1:0] rcv0_data = '0;
    logic           rcv0_ack;
    logic [7:0]     dbg_case = '0;
    logic           dbg_doit = 1'b0;
    logic [3:0]     dbg_leds;
    logic [3:0]     dbg_disp0;
    logic [3:0]     dbg_disp1;

    int n_cmp = 0;
    int n_bad = 0;

    // Packet-level reference model state.
    int m_pkt, m_err, m_last_addr, m_last_data;
    bit m_seeded, m_rng, m_red, m_seq;

    pakin_checker #(
        .PSZ(PSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .MIN_ADDR(1), .MAX_ADDR(14)
    ) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .rcv0_req(rcv0_req), .rcv0_data(rcv0_data), .rcv0_ack(rcv0_ack),
        .dbg_case(dbg_case), .dbg_doit(dbg_doit), .dbg_leds(dbg_leds),
        .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_clear();
        m_pkt = 0; m_err = 0; m_last_addr = 0; m_last_data = 0;
        m_seeded = 0; m_rng = 0; m_red = 0; m_seq = 0;
    endtask

    task automatic model_packet(input int a, input int d, input int r);
        bit rng, red, seq;
        rng = (a < 1) || (a > 14);
        red = (r != ((a ^ d) % 16));
        seq = m_seeded && (d != (m_last_data + 1) % 16);
        m_rng |= rng; m_red |= red; m_seq |= seq;
        if ((rng || red || seq) && m_err < 255) m_err++;
        m_pkt = (m_pkt + 1) % 256;
        m_seeded = 1;
        m_last_addr = a;
        m_last_data = d;
    endtask

    function automatic logic [3:0] exp_leds();
        return {m_seq, m_red, m_rng, m_seeded};
    endfunction

    function automatic logic [7:0] exp_sel(input int c);
        int v;
        case (c)
            0: v = m_pkt;
            1: v = m_err;
            2: v = m_last_addr;
            default: v = m_last_data;
        endcase
        return v[7:0];
    endfunction

    task automatic apply_reset();
        @(negedge i_clk);
        rcv0_req = 1'b0;
        dbg_doit = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge i_clk);
        reset = 1'b1;
        model_clear();
        #1;
    endtask

    // Full handshake; returns edges from req rise to ack rise and req fall to ack fall.
    task automatic send(input int a, input int d, input int r,
                        output int rise_n, output int fall_n);
        logic [5:0] a6;
        logic [3:0] d4, r4;
        a6 = a[5:0]; d4 = d[3:0]; r4 = r[3:0];
        @(negedge i_clk);
        rcv0_data = {a6, d4, r4};
        rcv0_req  = 1'b1;
        rise_n = 0;
        while (rise_n < 20 && rcv0_ack !== 1'b1) begin
            @(posedge i_clk); #1; rise_n++;
        end
        model_packet(a, d, r);
        @(negedge i_clk);
        rcv0_req = 1'b0;
        fall_n = 0;
        while (fall_n < 20 && rcv0_ack !== 1'b0) begin
            @(posedge i_clk); #1; fall_n++;
        end
    endtask

    task automatic snap(input int c, output logic [7:0] v);
        int up;
        logic [1:0] c2;
        up = $urandom_range(0, 63);
        c2 = c[1:0];
        @(negedge i_clk);
        dbg_case = {up[5:0], c2};
        dbg_doit = 1'b1;
        @(posedge i_clk); #1;
        v = {dbg_disp0, dbg_disp1};
        @(negedge i_clk);
        dbg_doit = 1'b0;
    endtask

    task automatic test_reset();
        int rn, fn;
        logic [7:0] v;
        @(negedge i_clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, rcv0_ack, dbg_leds, dbg_disp0, dbg_disp1} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got ready=%b ack=%b leds=%b disp=%h%h want all zero",
                     ready, rcv0_ack, dbg_leds, dbg_disp0, dbg_disp1);
        end
        @(negedge i_clk);
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_before_edge got %b want 0", ready);
        end
        @(posedge i_clk); #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_edge got %b want 1", ready);
        end
        send(3, 5, 6, rn, fn);
        n_cmp++;
        if (rn !== 4) begin
            n_bad++; $display("FAIL first_ack_latency got %0d want 4", rn);
        end
        n_cmp++;
        if (fn !== 3) begin
            n_bad++; $display("FAIL first_ack_release got %0d want 3", fn);
        end
        snap(0, v);
        n_cmp++;
        if (v !== 8'h01 || v !== exp_sel(0)) begin
            n_bad++; $display("FAIL first_pkt_cnt got %h want 01", v);
        end
        n_cmp++;
        if (dbg_leds !== 4'b0001) begin
            n_bad++; $display("FAIL first_leds got %b want 0001", dbg_leds);
        end
    endtask

    task automatic test_in_order();
        int rn, fn, d;
        logic [7:0] v;
        d = 6;
        for (int i = 0; i < 12; i++) begin
            send(3, d, (3 ^ d) % 16, rn, fn);
            d = (d + 1) % 16;
        end
        n_cmp++;
        if (rn !== 4 || fn !== 3) begin
            n_bad++; $display("FAIL stream_latency got %0d/%0d want 4/3", rn, fn);
        end
        snap(0, v);
        n_cmp++;
        if (v !== 8'd13) begin
            n_bad++; $display("FAIL stream_pkt_cnt got %0d want 13", v);
        end
        snap(1, v);
        n_cmp++;
        if (v !== 8'd0) begin
            n_bad++; $display("FAIL stream_err_cnt got %0d want 0", v);
        end
        n_cmp++;
        if (dbg_leds !== 4'b0001) begin
            n_bad++; $display("FAIL stream_leds got %b want 0001", dbg_leds);
        end
    endtask

    task automatic test_range();
        int rn, fn, d;
        logic [7:0] v;
        d = (m_last_data + 1) % 16;
        send(0, d, d % 16, rn, fn);
        d = (d + 1) % 16;
        send(15, d, (15 ^ d) % 16, rn, fn);
        snap(1, v);
        n_cmp++;
        if (v !== 8'd2) begin
            n_bad++; $display("FAIL range_err_cnt got %0d want 2", v);
        end
        n_cmp++;
        if (dbg_leds !== 4'b0011) begin
            n_bad++; $display("FAIL range_leds got %b want 0011", dbg_leds);
        end
        snap(2, v);
        n_cmp++;
        if (v !== 8'h0F) begin
            n_bad++; $display("FAIL range_last_addr got %h want 0f", v);
        end
    endtask

    task automatic test_combined();
        int rn, fn;
        logic [7:0] v;
        apply_reset();
        send(3, 5, 6, rn, fn);
        send(3, 9, 0, rn, fn);
        snap(1, v);
        n_cmp++;
        if (v !== 8'd1) begin
            n_bad++; $display("FAIL combined_err_cnt got %0d want 1", v);
        end
        n_cmp++;
        if (dbg_leds !== 4'b1101) begin
            n_bad++; $display("FAIL combined_leds got %b want 1101", dbg_leds);
        end
        snap(3, v);
        n_cmp++;
        if (v !== 8'h09) begin
            n_bad++; $display("FAIL combined_last_data got %h want 09", v);
        end
    endtask

    task automatic test_saturation();
        int rn, fn;
        logic [7:0] v;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            send(0, $urandom_range(0, 15), 8, rn, fn);
        end
        snap(1, v);
        n_cmp++;
        if (v !== 8'hFF || v !== exp_sel(1)) begin
            n_bad++; $display("FAIL sat_err_cnt got %h want ff", v);
        end
        snap(0, v);
        n_cmp++;
        if (v !== 8'd44 || v !== exp_sel(0)) begin
            n_bad++; $display("FAIL sat_pkt_cnt got %0d want 44", v);
        end
    endtask

    task automatic test_reset_mid();
        int rn, fn, n;
        logic [7:0] v;
        apply_reset();
        @(negedge i_clk);
        rcv0_data = {6'd7, 4'd2, 4'd5};
        rcv0_req  = 1'b1;
        n = 0;
        while (n < 20 && rcv0_ack !== 1'b1) begin
            @(posedge i_clk); #1; n++;
        end
        @(negedge i_clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rcv0_ack !== 1'b0 || dbg_leds !== 4'b0000) begin
            n_bad++; $display("FAIL mid_reset_drop got ack=%b leds=%b want 0/0000", rcv0_ack, dbg_leds);
        end
        @(negedge i_clk);
        reset = 1'b1;
        model_clear();
        rn = 0;
        while (rn < 20 && rcv0_ack !== 1'b1) begin
            @(posedge i_clk); #1; rn++;
        end
        model_packet(7, 2, 5);
        n_cmp++;
        if (rn !== 4) begin
            n_bad++; $display("FAIL mid_reack_latency got %0d want 4", rn);
        end
        @(negedge i_clk);
        rcv0_req = 1'b0;
        fn = 0;
        while (fn < 20 && rcv0_ack !== 1'b0) begin
            @(posedge i_clk); #1; fn++;
        end
        snap(0, v);
        n_cmp++;
        if (v !== 8'd1) begin
            n_bad++; $display("FAIL mid_pkt_cnt got %0d want 1", v);
        end
        snap(1, v);
        n_cmp++;
        if (v !== 8'd0) begin
            n_bad++; $display("FAIL mid_err_cnt got %0d want 0", v);
        end
        n_cmp++;
        if (dbg_leds !== 4'b0001) begin
            n_bad++; $display("FAIL mid_leds got %b want 0001", dbg_leds);
        end
    endtask

    task automatic test_random();
        int rn, fn, a, d, r;
        logic [7:0] v;
        apply_reset();
        for (int i = 0; i < 48; i++) begin
            a = $urandom_range(0, 63);
            if (m_seeded && $urandom_range(0, 3) != 0) d = (m_last_data + 1) % 16;
            else d = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) r = (a ^ d) % 16;
            else r = $urandom_range(0, 15);
            send(a, d, r, rn, fn);
            n_cmp++;
            if (rn !== 4 || fn !== 3) begin
                n_bad++; $display("FAIL rand_handshake pkt %0d got %0d/%0d want 4/3", i, rn, fn);
            end
            n_cmp++;
            if (dbg_leds !== exp_leds()) begin
                n_bad++; $display("FAIL rand_leds pkt %0d got %b want %b", i, dbg_leds, exp_leds());
            end
            if (i % 8 == 7) begin
                for (int c = 0; c < 4; c++) begin
                    snap(c, v);
                    n_cmp++;
                    if (v !== exp_sel(c)) begin
                        n_bad++; $display("FAIL rand_snap case %0d pkt %0d got %h want %h", c, i, v, exp_sel(c));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_range();
        test_combined();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pakin_checker.md
# pakin_checker

Receive-side packet sink and checker placed directly downstream of `pakout_io`'s SRC0 output. It consumes packets over a four-phase req/ack receive channel and validates each one for address range, redundancy field and data sequence. It keeps packet and error counters and drives the debug display/LED channel the test top muxes onto the 7-segment digits and LEDs. It lets a board test confirm, without a logic analyser, that every packet `pakout` emitted arrived intact.

## Interface
Parameters:
- `PSZ`, `` `NS_PACKET_SIZE ``, packet width; must equal `ASZ+DSZ+RSZ`.
- `ASZ`, `` `NS_ADDRESS_SIZE ``, address field width.
- `DSZ`, `` `NS_DATA_SIZE ``, data field width; must be >= `RSZ`.
- `RSZ`, `` `NS_REDUN_SIZE ``, redundancy field width; must be <= `ASZ`.
- `MIN_ADDR`, 1, lowest legal address, inclusive.
- `MAX_ADDR`, 14, highest legal address, inclusive.

Ports:
- `i_clk`, in, 1, sole clock.
- `reset`, in, 1, asynchronous, active-low.
- `ready`, out, 1, high from the first `i_clk` edge after `reset` deasserts.
- `rcv0_req`, in, 1, request. May come from a related slower clock, so it is synchronized internally.
- `rcv0_data`, in, `PSZ`, packet data. Must be stable while `rcv0_req` is high. Packet layout is {addr[`ASZ`], data[`DSZ`], redun[`RSZ`]}, with addr at the MSBs.
- `rcv0_ack`, out, 1, acknowledge.
- `dbg_case`, in, 8, selects the value to display.
- `dbg_doit`, in, 1, level. A rising edge snapshots the selected value.
- `dbg_leds`, out, 4, sticky status flags.
- `dbg_disp0`, out, 4, high nibble of the snapshot.
- `dbg_disp1`, out, 4, low nibble of the snapshot.

## Operation
- `rcv0_req` passes through a 2-flop synchronizer to give `req_s`. `rcv0_data` is sampled only in IDLE once `req_s` is high.
- FSM states:
  - IDLE: when `req_s`=1, capture `rcv0_data` into `pkt_r` and go to CHECK.
  - CHECK: evaluate `pkt_r`, update the counters and flags, set `rcv0_ack`=1, go to ACK.
  - ACK: hold `rcv0_ack`=1 until `req_s`=0, then clear `rcv0_ack` and go to IDLE.
- Checks on `pkt_r`; all three are evaluated independently, and one packet can raise several:
  - Range error: addr < `MIN_ADDR` or addr > `MAX_ADDR`.
  - Redundancy error: redun != addr[`RSZ`-1:0] ^ data[`RSZ`-1:0].
  - Sequence error: the `seeded` flag is set and data != (`last_data`+1) mod 2^`DSZ`.
- The first packet after reset sets `seeded` and is never a sequence error.
- `last_data` and `last_addr` update on every packet, including bad ones.
- `pkt_cnt` (8 bit) increments per packet and wraps from 255 to 0.
- `err_cnt` (8 bit) increments once per packet with any error and saturates at 255.
- `dbg_leds` = {seq_err_seen, red_err_seen, rng_err_seen, seeded}, bits [3:0] from MSB to LSB. The bits are sticky until reset.
- Debug select (bits [1:0] of `dbg_case`; the upper bits are ignored):
  - 0: `pkt_cnt`
  - 1: `err_cnt`
  - 2: {zero-pad, `last_addr`}, truncated to 8 bits
  - 3: {zero-pad, `last_data`}, truncated to 8 bits
- On a `dbg_doit` 0->1 edge, detected against a registered copy, latch the selected 8-bit value: `dbg_disp0` = [7:4], `dbg_disp1` = [3:0].
- If a snapshot coincides with a CHECK update, it captures the pre-update value.
- `dbg_case` changes have no effect until the next edge.

## Timing
- Reset values: `ready`=0, `rcv0_ack`=0, `dbg_leds`=0, `dbg_disp0`=0, `dbg_disp1`=0. The FSM is in IDLE; the counters, `seeded`, `last_*` and the synchronizer are all 0.
- Latency from the `rcv0_req` rise: `req_s` high after 2 edges, capture on edge 3, `rcv0_ack` high after edge 4.
- Counters and flags become visible on the same edge as `rcv0_ack` rises.
- Ack release: `rcv0_ack` falls 1 edge after `req_s` falls, i.e. 3 edges after the `rcv0_req` fall.
- Back-to-back packets: a new request is honoured only after `rcv0_ack` has returned low and the FSM is in IDLE.
- A `rcv0_req` pulse shorter than 2 clocks is not guaranteed to be seen.
- Asynchronous reset assertion mid-handshake:
  - `rcv0_ack` drops immediately and all state clears.
  - After release, if `rcv0_req` is still high, that packet is captured anew as the first (seed) packet.

## Test plan
Bench configuration: `ASZ`=6, `DSZ`=4, `RSZ`=4, `PSZ`=14, `MIN_ADDR`=1, `MAX_ADDR`=14.

- Reset release: `ready` rises 1 edge later and all outputs are 0. Then send addr=3, data=5, redun=6. `rcv0_ack` rises 4 edges after req; snapshot case 0 gives disp=0/1, `dbg_leds`=0001.
- In-order stream: send data 5,6,...,15,0,1 at addr 3, each with a correct redun. Expect `pkt_cnt`=13, `err_cnt`=0, `dbg_leds`=0001, and the 15->0 wrap is accepted.
- Range errors: send addr=0 then addr=15, each with a correct redun and data in sequence. Expect `err_cnt`=2, `dbg_leds`=0011; snapshot case 2 gives disp=0/F.
- Combined error: send a packet with a bad redun and a data skip (last=5, send 9). Expect `err_cnt` +1 only, `dbg_leds`=1101.
- Saturation: force 300 bad packets. Expect `err_cnt`=255 (disp=F/F) and `pkt_cnt`=44 (300 mod 256).
- Reset mid-handshake: assert reset while in ACK, then release with req still high. `rcv0_ack` drops immediately, the packet is re-acked as the seed, `pkt_cnt`=1, `err_cnt`=0.
